tetris_line_clear: RTL and testbench
====================================

Name: tetris_line_clear

Overview:
- Parametrised line-clear and collapse engine for the Tetris core. Generalises the core's fixed 10x20, 4-bit-cell board to any width, height and cell width.
- After a piece locks, the game FSM pulses start. The engine scans the board bottom-up one row per cycle, drops full rows, compacts the remaining rows downward and zero-fills the top.
- The board storage stays in the game core and is reached through one combinational row-read port and one row-write port.

Parameters:
- BOARD_W, 10, cells per row
- BOARD_H, 20, rows; row 0 is the top
- CELL_W, 4, bits per cell; 0 = empty, nonzero = piece type
- SCORE_W, 20, score accumulator width (used only with TETRIS_SCORE_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to begin a clear pass
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse when the pass completes
- lines_cleared  out  $clog2(BOARD_H+1)  full rows removed in the last pass; held until the next start
- rd_addr  out  $clog2(BOARD_H)  row-read address
- rd_data  in  BOARD_W*CELL_W  row contents at rd_addr, same cycle (combinational)
- wr_en  out  1  row-write strobe
- wr_addr  out  $clog2(BOARD_H)  row-write address
- wr_data  out  BOARD_W*CELL_W  row to write; cell c occupies bits [c*CELL_W +: CELL_W]
- level  in  4  current level (used only with TETRIS_SCORE_EN)
- score  out  SCORE_W  running score (present only with TETRIS_SCORE_EN)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; busy=0, done=0, lines_cleared=0, wr_en=0, rd_addr=BOARD_H-1, wr_addr=0, wr_data=0, score=0.
- State IDLE:
  - start=1 moves to SCAN.
  - On entry to SCAN: rd_ptr=BOARD_H-1, wr_ptr=BOARD_H-1, count=0; busy goes high the next cycle.
- State SCAN (one cycle per row, rd_addr=rd_ptr):
  - A row is full when every cell is nonzero.
  - Full row: count+1, wr_en=0, wr_ptr unchanged.
  - Non-full row: wr_en=1, wr_addr=wr_ptr, wr_data=rd_data, then wr_ptr-1. This write happens even when wr_ptr==rd_ptr; it is harmless and keeps the timing uniform.
  - rd_ptr decrements each cycle. When the row at rd_ptr=0 is processed: count==0 goes to DONE; otherwise go to FILL.
- State FILL:
  - wr_en=1, wr_addr=wr_ptr, wr_data=0, then wr_ptr-1.
  - Runs exactly count cycles (the cycle that writes row 0 is the last), then goes to DONE.
- State DONE (one cycle): done=1, lines_cleared=count, busy=0, then IDLE.
- Latency from the start cycle to the done pulse: 1 + BOARD_H + count cycles.
- start while busy is ignored. start in the same cycle as the done pulse is also ignored.
- Boundaries:
  - All rows full: SCAN writes nothing, FILL zeroes all BOARD_H rows, lines_cleared=BOARD_H.
  - Empty board: BOARD_H writes of zero rows, lines_cleared=0.
  - Pointers never wrap. wr_ptr stops at 0, and FILL terminates on the write to row 0.
- Reset mid-pass returns immediately to IDLE with reset outputs. The board may be partly compacted; the game core resets the board on the same rst.
- A cell counts as filled for any nonzero value; cell values are copied unmodified.

Optional Feature:
- Macro TETRIS_SCORE_EN.
- Defined:
  - The score port exists.
  - In the DONE cycle, score += base(count) * (level+1), with base = 0, 40, 100, 300, 1200 for 0, 1, 2, 3, >=4 lines.
  - The product is computed at SCORE_W+4 bits. The score saturates at 2^SCORE_W-1.
  - The score is cleared only by rst.
- Undefined: no score port, no multiplier; lines_cleared behaviour is identical.

Decomposition:
- Package tetris_pkg holds: the state enum (IDLE, SCAN, FILL, DONE), the default BOARD_W/BOARD_H/CELL_W constants shared with the game core, and the score base table.
- One sub-module, tetris_row_full: combinational, parametrised by BOARD_W and CELL_W; takes a row and returns 1 when all cells are nonzero. It is reused by the game core's spawn/collision logic.

Test Plan:
- Empty 10x20 board, start pulse -> 20 writes of zero rows to rows 19..0; done 21 cycles after start; lines_cleared=0.
- Rows 19 and 17 full, row 18 holds pattern A, row 16 holds pattern B:
  - Response: row 19 <- A, row 18 <- B, rows above shifted down by 2, rows 1..0 zeroed; lines_cleared=2; done at cycle 23.
- Rows 16..19 full, level=2 with TETRIS_SCORE_EN -> lines_cleared=4, score increases by 3600; a second identical pass gives score 7200.
- start pulsed again mid-SCAN -> ignored; exactly one done pulse and a correct result.
- rst asserted 5 cycles into SCAN -> next cycle busy=0, wr_en=0, lines_cleared=0, state IDLE; a subsequent start completes normally.
- Parametrised instance BOARD_W=4, BOARD_H=4, all rows full -> 4 zero-row writes, lines_cleared=4, done 9 cycles after start.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris line-clear engine: FSM states, default board geometry
// and the score base table used when TETRIS_SCORE_EN is defined.
package tetris_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FILL,
    DONE
  } state_e;

  localparam int DEF_BOARD_W = 10;
  localparam int DEF_BOARD_H = 20;
  localparam int DEF_CELL_W  = 4;

  // Points awarded per pass before the level multiplier; four or more rows count as a tetris.
  function automatic logic [10:0] score_base(input int unsigned lines);
    case (lines)
      0:       return 11'd0;
      1:       return 11'd40;
      2:       return 11'd100;
      3:       return 11'd300;
      default: return 11'd1200;
    endcase
  endfunction

endpackage

// File: rtl/tetris_row_full.sv
// Combinational full-row detector: high when every cell of the row is nonzero.
// Shared with the game core's spawn/collision logic.
module tetris_row_full
  import tetris_pkg::*;
#(
  parameter int BOARD_W = DEF_BOARD_W,
  parameter int CELL_W  = DEF_CELL_W
) (
  input  logic [BOARD_W*CELL_W-1:0] row,
  output logic                      full
);

  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    full = 1'b1;
    for (int c = 0; c < BOARD_W; c++) begin
      if (row[c*CELL_W +: CELL_W] == '0) full = 1'b0;
    end
  end

endmodule

// File: rtl/tetris_line_clear.sv
// Line-clear and collapse engine: scans the board bottom-up, drops full rows, compacts and
// zero-fills the top. Optional scoring is enabled by defining TETRIS_SCORE_EN.
module tetris_line_clear
  import tetris_pkg::*;
#(
  parameter int BOARD_W = DEF_BOARD_W,
  parameter int BOARD_H = DEF_BOARD_H,
  parameter int CELL_W  = DEF_CELL_W,
  parameter int SCORE_W = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(BOARD_H+1)-1:0] lines_cleared,
  output logic [$clog2(BOARD_H)-1:0]   rd_addr,
  input  logic [BOARD_W*CELL_W-1:0]    rd_data,
  output logic                         wr_en,
  output logic [$clog2(BOARD_H)-1:0]   wr_addr,
  output logic [BOARD_W*CELL_W-1:0]    wr_data,
  input  logic [3:0]                   level
`ifdef TETRIS_SCORE_EN
  ,
  output logic [SCORE_W-1:0]           score
`endif
);

  localparam int AW = $clog2(BOARD_H);
  localparam int CW = $clog2(BOARD_H+1);

  state_e          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   lines_q, lines_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            row_full;

  tetris_row_full #(
    .BOARD_W (BOARD_W),
    .CELL_W  (CELL_W)
  ) u_row_full (
    .row  (rd_data),
    .full (row_full)
  );

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    lines_d  = lines_q;
    wr_en    = 1'b0;
    wr_data  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SCAN;
          rd_ptr_d = AW'(BOARD_H-1);
          wr_ptr_d = AW'(BOARD_H-1);
          count_d  = '0;
          lines_d  = '0;
        end
      end
      SCAN: begin
        if (row_full) begin
          count_d = count_q + CW'(1);
        end else begin
          wr_en   = 1'b1;
          wr_data = rd_data;
          if (wr_ptr_q != '0) wr_ptr_d = wr_ptr_q - AW'(1);
        end
        if (rd_ptr_q == '0) state_d = (count_d == '0) ? DONE : FILL;
        else                rd_ptr_d = rd_ptr_q - AW'(1);
      end
      // Zero-fills the top count rows; wr_ptr reaches row 0 exactly on the last fill write.
      FILL: begin
        wr_en = 1'b1;
        if (wr_ptr_q == '0) state_d = DONE;
        else                wr_ptr_d = wr_ptr_q - AW'(1);
      end
      DONE: begin
        state_d  = IDLE;
        rd_ptr_d = AW'(BOARD_H-1);
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE) lines_d = count_d;
    busy_d = (state_d == SCAN) || (state_d == FILL);
    done_d = (state_d == DONE);
  end

`ifdef TETRIS_SCORE_EN
  localparam int PW = SCORE_W + 4;
  localparam logic [PW:0] SCORE_MAX = (PW+1)'({SCORE_W{1'b1}});

  logic [SCORE_W-1:0] score_q, score_d;
  logic [PW-1:0]      product;
  logic [PW:0]        sum;

  always_comb begin
    product = PW'(score_base(int'(count_d))) * PW'({1'b0, level} + 5'd1);
    sum     = {1'b0, PW'(score_q)} + {1'b0, product};
    score_d = score_q;
    if (state_d == DONE) score_d = (sum > SCORE_MAX) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  end

  assign score = score_q;
`else
  logic unused_level;
  localparam int unused_score_w = SCORE_W;
  assign unused_level = ^level;
`endif

  // NOTE: sequential state uses non-blocking assignments only; rst is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= AW'(BOARD_H-1);
      wr_ptr_q <= '0;
      count_q  <= '0;
      lines_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TETRIS_SCORE_EN
      score_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      lines_q  <= lines_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef TETRIS_SCORE_EN
      score_q  <= score_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_cleared = lines_q;
  assign rd_addr       = rd_ptr_q;
  assign wr_addr       = wr_ptr_q;

endmodule

// File: tb/tb_tetris_line_clear.sv
// Self-checking bench for tetris_line_clear: a row-level board model predicts the write
// stream, busy/done timeline and final board; directed passes pin latency and results.
module tb_tetris_line_clear;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int CW = 4;
  localparam int SH = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [39:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  level;
  logic        busy, done, wr_en;
  logic [4:0]  lines_cleared, rd_addr, wr_addr;
  logic [39:0] rd_data, wr_data;
`ifdef TETRIS_SCORE_EN
  logic [19:0] score, s_score;
`endif

  logic        s_start, s_busy, s_done, s_wr_en;
  logic [2:0]  s_lines;
  logic [1:0]  s_rd_addr, s_wr_addr;
  logic [15:0] s_rd_data, s_wr_data;

  logic [39:0] board [H];
  logic [39:0] img [H];
  logic        load_en;
  logic [15:0] s_board [SH];
  logic [15:0] s_img [SH];
  logic        s_load_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tetris_line_clear #(.BOARD_W(W), .BOARD_H(H), .CELL_W(CW), .SCORE_W(20)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .level(level)
`ifdef TETRIS_SCORE_EN
    , .score(score)
`endif
  );

  tetris_line_clear #(.BOARD_W(4), .BOARD_H(SH), .CELL_W(CW), .SCORE_W(20)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .lines_cleared(s_lines), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .level(level)
`ifdef TETRIS_SCORE_EN
    , .score(s_score)
`endif
  );

  // Board storage as the game core would hold it.
  always @(posedge clk) begin
    if (load_en) board <= img;
    else if (wr_en) board[wr_addr] <= wr_data;
    if (s_load_en) s_board <= s_img;
    else if (s_wr_en) s_board[s_wr_addr] <= s_wr_data;
  end
  assign rd_data   = board[rd_addr];
  assign s_rd_data = s_board[s_rd_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_full(input logic [39:0] r);
    for (int c = 0; c < W; c++) if (r[c*CW +: CW] == 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [39:0] pat_row(input int r);
    logic [39:0] v = '0;
    for (int c = 0; c < W; c++) v[c*CW +: CW] = (c == r % W) ? 4'h0 : 4'((r + c) % 15 + 1);
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  bit          armed = 1'b0;
  bit          m_busy, m_done;
  int          m_rem, m_count, m_lines, n_writes;
  wr_t         exp_q [$];
  logic [39:0] exp_board [H];

  task automatic plan_pass();
    int dst = H - 1;
    m_count = 0;
    exp_q.delete();
    for (int r = H - 1; r >= 0; r--) begin
      if (is_full(board[r])) m_count++;
      else begin
        exp_q.push_back('{addr: 5'(dst), data: board[r]});
        exp_board[dst] = board[r];
        dst--;
      end
    end
    for (; dst >= 0; dst--) begin
      exp_q.push_back('{addr: 5'(dst), data: 40'h0});
      exp_board[dst] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("lines_cleared", lines_cleared, m_lines);
      if (wr_en) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0h, expected no write", wr_addr, wr_data);
        end else begin
          check("wr_addr", wr_addr, exp_q[0].addr);
          check("wr_data", wr_data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
    end
    if (rst) begin
      armed = 1'b1;
      m_busy = 0; m_done = 0; m_lines = 0; m_rem = 0;
      exp_q.delete();
    end else if (start && !m_busy && !m_done) begin
      plan_pass();
      n_writes = 0;
      m_busy = 1; m_done = 0; m_lines = 0;
      m_rem = H + m_count - 1;
    end else if (m_busy) begin
      if (m_rem > 0) m_rem--;
      else begin
        m_busy = 0; m_done = 1; m_lines = m_count;
      end
    end else begin
      m_done = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load();
    load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic run_pass(input int extra_at, output int lat, output int dones);
    start = 1'b1;
    lat = 0;
    dones = 0;
    while (dones == 0 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      start = (extra_at > 0 && lat == extra_at);
      if (done) dones++;
    end
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("single_done_pulse", dones, 1);
  endtask

  task automatic compare_board(input string name);
    int bad = 0;
    for (int r = 0; r < H; r++) if (board[r] !== exp_board[r]) bad++;
    check(name, bad, 0);
  endtask

  task automatic set_test3_img();
    for (int r = 0; r < 16; r++) img[r] = pat_row(r);
    img[16] = 40'hF0F0F0F0F0;
    img[17] = 40'h123456789A;
    img[18] = 40'h0102030405;
    img[19] = 40'hFFFFFFFFFF;
  endtask

  initial begin
    int lat, dones, bad;
    rst = 1'b1; start = 1'b0; level = 4'd0;
    load_en = 1'b0; s_load_en = 1'b0; s_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_lines", lines_cleared, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_rd_addr", rd_addr, H - 1);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 0);
    check("reset_small_rd_addr", s_rd_addr, SH - 1);
`ifdef TETRIS_SCORE_EN
    check("reset_score", score, 0);
`endif
    rst = 1'b0;

    // Four full rows at the bottom, level 2, run twice from a fresh score.
    for (int r = 0; r < 16; r++) img[r] = pat_row(r);
    img[16] = 40'h123456789A; img[17] = 40'hFFFFFFFFFF;
    img[18] = 40'h8888888888; img[19] = 40'h1111111111;
    level = 4'd2;
    load();
    run_pass(0, lat, dones);
    check("tetris_latency", lat, 25);
    check("tetris_lines", lines_cleared, 4);
    check("tetris_row19", board[19], pat_row(15));
    check("tetris_row3", board[3], 0);
    compare_board("tetris_board");
`ifdef TETRIS_SCORE_EN
    check("tetris_score_1", score, 3600);
`endif
    load();
    run_pass(0, lat, dones);
    check("tetris2_lines", lines_cleared, 4);
`ifdef TETRIS_SCORE_EN
    check("tetris_score_2", score, 7200);
`endif
    level = 4'd0;

    // Empty board: every row rewritten as zero, nothing cleared.
    for (int r = 0; r < H; r++) img[r] = '0;
    load();
    run_pass(0, lat, dones);
    check("empty_latency", lat, 21);
    check("empty_lines", lines_cleared, 0);
    check("empty_write_count", n_writes, 20);
    compare_board("empty_board");

    // Rows 19 and 17 full with A and B between them.
    set_test3_img();
    load();
    run_pass(0, lat, dones);
    check("two_latency", lat, 23);
    check("two_lines", lines_cleared, 2);
    check("two_row19_is_A", board[19], 40'h0102030405);
    check("two_row18_is_B", board[18], 40'hF0F0F0F0F0);
    check("two_row17", board[17], pat_row(15));
    check("two_row2", board[2], pat_row(0));
    check("two_row1", board[1], 0);
    check("two_row0", board[0], 0);
    compare_board("two_board");

    // Extra start mid-SCAN must be ignored.
    load();
    run_pass(5, lat, dones);
    check("midstart_latency", lat, 23);
    check("midstart_lines", lines_cleared, 2);
    compare_board("midstart_board");

    // Reset five cycles into SCAN, then a clean pass.
    load();
    start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_lines", lines_cleared, 0);
    check("midrst_done", done, 0);
    set_test3_img();
    load();
    run_pass(0, lat, dones);
    check("after_rst_latency", lat, 23);
    check("after_rst_lines", lines_cleared, 2);
    compare_board("after_rst_board");

    // 4x4 instance with every row full.
    for (int r = 0; r < SH; r++) s_img[r] = 16'h1234 + 16'(r * 16'h1111);
    s_load_en = 1'b1;
    @(posedge clk); #1;
    s_load_en = 1'b0;
    begin
      int s_writes = 0, s_nonzero = 0, s_lat = 0, s_dones = 0;
      s_start = 1'b1;
      while (s_dones == 0 && s_lat < 50) begin
        if (s_wr_en) begin
          s_writes++;
          if (s_wr_data != 16'h0) s_nonzero++;
        end
        @(posedge clk); #1;
        s_lat++;
        s_start = 1'b0;
        if (s_done) s_dones++;
      end
      check("small_done_seen", s_dones, 1);
      check("small_latency", s_lat, 9);
      check("small_lines", s_lines, 4);
      check("small_writes", s_writes, 4);
      check("small_nonzero_writes", s_nonzero, 0);
      bad = 0;
      for (int r = 0; r < SH; r++) if (s_board[r] !== 16'h0) bad++;
      check("small_board_zero", bad, 0);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
